// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_pkg
// Description : Shared UART constants and the per-cycle FIFO operation type.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_fifo_pkg;

    localparam int c_CLK_PER_BIT     = 868;
    localparam int c_UART_WIDTH      = 8;
    localparam int c_DEF_DEPTH_LOG2  = 4;

    typedef enum logic [1:0] {
        FIFO_IDLE     = 2'd0,
        FIFO_PUSH     = 2'd1,
        FIFO_POP      = 2'd2,
        FIFO_PUSH_POP = 2'd3
    } fifo_op_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Receiver-side capture and consumer-side valid/ready bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = c_DEF_DEPTH_LOG2,
    parameter int WIDTH      = c_UART_WIDTH
);
    logic                  clear;
    logic [WIDTH-1:0]      rx_data;
    logic                  rx_busy;
    logic                  rx_okay;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  overflow;
    logic                  frame_err;

    // master is the FIFO itself; slave is the receiver/consumer environment
    modport master (
        input  clear, rx_data, rx_busy, rx_okay, out_ready,
        output out_data, out_valid, count, full, overflow, frame_err
    );

    modport slave (
        output clear, rx_data, rx_busy, rx_okay, out_ready,
        input  out_data, out_valid, count, full, overflow, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : Register-array storage, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  wire logic              CLK100MHZ,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [WIDTH-1:0]  wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge CLK100MHZ) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Captures one byte per received UART frame into a FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = c_DEF_DEPTH_LOG2,
    parameter int WIDTH      = c_UART_WIDTH
) (
    input  wire logic       CLK100MHZ,
    input  wire logic       reset,
    uart_rx_fifo_if.master  bus
);
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                r_busy_q;
    logic                r_overflow;
    logic                r_frame_err;

    logic                w_end_pulse;
    logic                w_push_req;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_overflow_set;
    fifo_op_e            w_op;

    assign w_end_pulse = r_busy_q & ~bus.rx_busy;
    assign w_push_req  = w_end_pulse & bus.rx_okay;
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                         (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);

    // A full FIFO still accepts a byte when the head is leaving in the same cycle
    assign w_pop          = ~bus.clear & ~w_empty & bus.out_ready;
    assign w_push         = ~bus.clear & w_push_req & (~w_full | w_pop);
    assign w_overflow_set = ~bus.clear & w_push_req & w_full & ~w_pop;

    always_comb begin
        w_op = FIFO_IDLE;
        case ({w_push, w_pop})
            2'b10:   w_op = FIFO_PUSH;
            2'b01:   w_op = FIFO_POP;
            2'b11:   w_op = FIFO_PUSH_POP;
            default: w_op = FIFO_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_busy_q    <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_busy_q <= bus.rx_busy;
            if (bus.clear) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_overflow  <= 1'b0;
                r_frame_err <= 1'b0;
            end else begin
                case (w_op)
                    FIFO_PUSH:     r_wr_ptr <= r_wr_ptr + 1'b1;
                    FIFO_POP:      r_rd_ptr <= r_rd_ptr + 1'b1;
                    FIFO_PUSH_POP: begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    default: ;
                endcase
                if (w_overflow_set) begin
                    r_overflow <= 1'b1;
                end
                if (w_end_pulse & ~bus.rx_okay) begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    uart_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .WIDTH  (WIDTH)
    ) u_mem (
        .CLK100MHZ (CLK100MHZ),
        .we        (w_push),
        .waddr     (r_wr_ptr[DEPTH_LOG2-1:0]),
        .wdata     (bus.rx_data),
        .raddr     (r_rd_ptr[DEPTH_LOG2-1:0]),
        .rdata     (bus.out_data)
    );

    assign bus.out_valid = ~w_empty;
    assign bus.count     = r_wr_ptr - r_rd_ptr;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.frame_err = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
    logic CLK100MHZ = 1'b0;
    logic reset     = 1'b1;
    int   checks    = 0;
    int   errors    = 0;

    uart_rx_fifo_if #(.DEPTH_LOG2(4), .WIDTH(8)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .bus       (bus.master)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    // Receiver frame: busy for 5 cycles, then falls; returns after the capture edge
    task automatic send(input logic [7:0] d, input logic ok);
        bus.rx_data = d;
        bus.rx_okay = ok;
        bus.rx_busy = 1'b1;
        repeat (5) step();
        bus.rx_busy = 1'b0;
        step();
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_busy   = 1'b0;
        bus.rx_okay   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) step();
        check("rst_valid",    bus.out_valid, 0);
        check("rst_count",    bus.count,     0);
        check("rst_full",     bus.full,      0);
        check("rst_overflow", bus.overflow,  0);
        check("rst_frame",    bus.frame_err, 0);
        reset = 1'b0;
        step();

        // Single byte
        send(8'h2B, 1'b1);
        check("single_valid", bus.out_valid, 1);
        check("single_data",  bus.out_data,  8'h2B);
        check("single_count", bus.count,     1);
        pop_one();
        check("single_pop_count", bus.count,     0);
        check("single_pop_valid", bus.out_valid, 0);

        // Order and wrap
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
        check("fill_full",  bus.full,  1);
        check("fill_count", bus.count, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("order_%0d", i), bus.out_data, i);
            pop_one();
        end
        check("drain_count", bus.count, 0);
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b1);
        check("wrap_count", bus.count, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wrap_%0d", i), bus.out_data, 8'h10 + i);
            pop_one();
        end
        check("wrap_empty", bus.out_valid, 0);

        // Overflow
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b1);
        send(8'hAA, 1'b1);
        check("ovf_flag",  bus.overflow, 1);
        check("ovf_count", bus.count,    16);
        check("ovf_head",  bus.out_data, 8'h20);
        bus.rx_data = 8'hBB;
        bus.rx_okay = 1'b1;
        bus.rx_busy = 1'b1;
        repeat (5) step();
        bus.rx_busy   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("fullpop_count", bus.count,    16);
        check("fullpop_ovf",   bus.overflow, 1);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("ovf_order_%0d", i), bus.out_data, 8'h20 + i);
            pop_one();
        end
        check("ovf_last", bus.out_data, 8'hBB);
        pop_one();
        check("ovf_drained", bus.out_valid, 0);

        // Framing error
        send(8'h55, 1'b0);
        check("ferr_flag",  bus.frame_err, 1);
        check("ferr_count", bus.count,     0);
        send(8'h3E, 1'b1);
        check("ferr_good_data",  bus.out_data,  8'h3E);
        check("ferr_good_count", bus.count,     1);
        check("ferr_sticky",     bus.frame_err, 1);

        // Clear priority over a coinciding frame end and pop
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        check("clr_pre_count", bus.count, 3);
        bus.rx_data = 8'h77;
        bus.rx_okay = 1'b1;
        bus.rx_busy = 1'b1;
        repeat (5) step();
        bus.rx_busy   = 1'b0;
        bus.out_ready = 1'b1;
        bus.clear     = 1'b1;
        step();
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        check("clr_count",    bus.count,     0);
        check("clr_overflow", bus.overflow,  0);
        check("clr_frame",    bus.frame_err, 0);
        check("clr_valid",    bus.out_valid, 0);
        step();
        check("clr_no_spurious", bus.count, 0);

        // Async reset with count=5 and overflow=1
        for (int i = 0; i < 17; i++) send(8'(8'h40 + i), 1'b1);
        for (int i = 0; i < 11; i++) pop_one();
        check("ar_pre_count", bus.count,    5);
        check("ar_pre_ovf",   bus.overflow, 1);
        @(posedge CLK100MHZ);
        #3;
        reset = 1'b1;
        #1;
        check("ar_count", bus.count,     0);
        check("ar_valid", bus.out_valid, 0);
        check("ar_ovf",   bus.overflow,  0);
        step();
        reset = 1'b0;
        step();
        check("ar_post_count", bus.count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte FIFO directly downstream of the UART receiver.
- Watches the receiver's busy/okay/data outputs and captures exactly one byte per completed frame.
- Buffers received bytes and presents them to the consumer (program loader / executor) over a valid/ready handshake.
- Replaces the ad-hoc has_data/data_saved capture logic in the top level, and reports overflow and framing errors as sticky flags.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 = 16 entries.
WIDTH, 8, data width in bits.

Ports:
clock  in  1  system clock (100 MHz).
reset  in  1  asynchronous, active-high reset.
clear  in  1  synchronous flush: empties the FIFO and clears the sticky flags.
rx_data  in  WIDTH  receiver data bits (stop/start stripped).
rx_busy  in  1  receiver is shifting data bits.
rx_okay  in  1  receiver frame valid (start=0, stop=1).
out_data  out  WIDTH  head-of-FIFO byte; valid only while out_valid=1.
out_valid  out  1  FIFO not empty.
out_ready  in  1  consumer accepts the head byte.
count  out  DEPTH_LOG2+1  number of stored bytes.
full  out  1  count == depth.
overflow  out  1  sticky: a byte was dropped because the FIFO was full.
frame_err  out  1  sticky: a frame ended with rx_okay=0.

Behaviour:
- Reset (async, active-high): pointers=0, count=0, overflow=0, frame_err=0, busy_q=0. Outputs: out_valid=0, full=0, out_data=mem[0] (don't-care). Memory contents are not reset.
- Frame end detection: busy_q <= rx_busy every cycle. end_pulse = busy_q & ~rx_busy (one cycle per frame).
  - end_pulse & rx_okay → push request with rx_data.
  - end_pulse & ~rx_okay → no push; frame_err <= 1.
- Pop: pop = out_valid & out_ready. Pop with out_valid=0 is ignored.
- Latency: push written at the clock edge ending the end_pulse cycle. out_valid=1 and out_data correct from the next cycle.
- out_data is combinational from mem[rd_ptr] (first-word fall-through). After a pop, the next byte is visible the following cycle.
- Pointers: wr_ptr and rd_ptr are DEPTH_LOG2+1 bits with an extra wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and lower bits are equal.
  - Pointers wrap modulo 2**(DEPTH_LOG2+1). count = wr_ptr - rd_ptr, truncated to width.
- Push while full, no pop: byte dropped, pointers unchanged, overflow <= 1.
- Push while full with a pop in the same cycle: both occur, count unchanged, no overflow.
- Push and pop while not empty: both occur, count unchanged.
- Push while empty: stored. out_valid rises next cycle (no same-cycle bypass).
- clear: priority over push/pop in the same cycle.
  - rd_ptr=wr_ptr=0, count=0, overflow=0, frame_err=0.
  - A coinciding end_pulse is discarded.
  - busy_q is still updated, so no spurious end_pulse follows.
- Reset mid-frame: FIFO and flags are cleared.
  - If rx_busy is still 1 after reset release and later falls, that frame is captured normally. The receiver shares the same reset, so this does not occur in the top level.
- Sticky flags are cleared only by reset or clear.

Decomposition:
- Shared include uart_defs.vh holds CLK_PER_BIT=868, UART_WIDTH=8, and the default DEPTH_LOG2=4; uart_send, uart_recv and this block all use it.
- One sub-module: uart_fifo_mem.
  - 2**DEPTH_LOG2 x WIDTH register array, synchronous write (we, waddr, wdata).
  - Asynchronous read (raddr → rdata).
  - No reset of the array.
- Pointer, flag and edge-detect logic stays in uart_rx_fifo.

Test Plan:
- Single byte: after reset, drive rx_busy 1 for 5 cycles then 0 with rx_okay=1, rx_data=0x2B, out_ready=0 → out_valid=1 and out_data=0x2B one cycle after busy falls, count=1; pulse out_ready → count=0, out_valid=0 next cycle.
- Order and wrap: push 0x00..0x0F (16 frames) → full=1, count=16; pop all → outputs 0x00..0x0F in order; push 0x10..0x14 → pointers wrapped, outputs 0x10..0x14.
- Overflow: fill 16 bytes, push 0xAA with no pop → overflow=1, count=16, 0xAA never appears; push 0xBB on the same cycle as a pop while full → count stays 16, overflow unchanged, 0xBB output last.
- Framing error: busy falls with rx_okay=0, rx_data=0x55 → frame_err=1, count unchanged; next good frame 0x3E → stored normally, frame_err stays 1.
- Clear priority: with count=3, assert clear on the same cycle as an end_pulse carrying 0x77 and out_ready=1 → count=0, overflow=0, frame_err=0, out_valid=0; 0x77 not stored.
- Async reset: assert reset mid-cycle with count=5 and overflow=1 → count=0, out_valid=0, overflow=0 immediately (before the next clock edge).
